// File: rtl/pixel_frame_writer.sv
// Pixel-write sink: a small FIFO in front of a 160x120x3 frame RAM port, with
// single-pixel readback and a full-frame clear sequencer.
module pixel_frame_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [6:0]  in_y,
    input  logic [2:0]  in_colour,
    output logic        err_oob,
    input  logic        rd_req,
    input  logic [7:0]  rd_x,
    input  logic [6:0]  rd_y,
    output logic        rd_valid,
    output logic [2:0]  rd_colour,
    input  logic        clear_req,
    input  logic [2:0]  clear_colour,
    output logic        clear_done,
    output logic        busy,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [2:0]  mem_wdata,
    input  logic [2:0]  mem_rdata
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [14:0]   LAST_ADDR = 15'(WIDTH * HEIGHT - 1);
    localparam logic [7:0]    X_LIM     = 8'(WIDTH);
    localparam logic [6:0]    Y_LIM     = 7'(HEIGHT);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_READ_WAIT, S_CLEAR} state_t;

    function automatic logic [14:0] pix_addr(input logic [6:0] y, input logic [7:0] x);
        return 15'(y) * 15'(WIDTH) + 15'(x);
    endfunction

    state_t          state_q;
    logic [14:0]     fifo_addr_q [FIFO_DEPTH];
    logic [2:0]      fifo_col_q  [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready_q, err_oob_q, rd_valid_q, clear_done_q, mem_we_q;
    logic [2:0]      rd_colour_q, mem_wdata_q, clr_col_q;
    logic [14:0]     mem_addr_q, clr_cnt_q;
    logic            rd_oob_q, clr_pend_q;

    logic push, store, pop, in_oob, rd_oob;

    assign in_oob = (in_x >= X_LIM) || (in_y >= Y_LIM);
    assign rd_oob = (rd_x >= X_LIM) || (rd_y >= Y_LIM);
    assign push   = in_valid && in_ready_q;
    assign store  = push && !in_oob;
    assign pop    = (state_q == S_WRITE) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({store, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Entries hold the precomputed RAM address so the drain path is a plain register copy.
    always_ff @(posedge clk) begin
        if (store) begin
            fifo_addr_q[wr_ptr_q] <= pix_addr(in_y, in_x);
            fifo_col_q[wr_ptr_q]  <= in_colour;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b0;
            err_oob_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_colour_q  <= '0;
            clear_done_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            clr_col_q    <= '0;
            clr_cnt_q    <= '0;
            rd_oob_q     <= 1'b0;
            clr_pend_q   <= 1'b0;
        end else begin
            mem_we_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            clear_done_q <= 1'b0;
            err_oob_q    <= push && in_oob;
            count_q      <= count_d;
            in_ready_q   <= (count_d != FULL);
            if (store) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);

            // A clear pulse seen while writing or reading is remembered; during a clear it is lost.
            if (clear_req && state_q != S_IDLE && state_q != S_CLEAR) begin
                clr_pend_q <= 1'b1;
                clr_col_q  <= clear_colour;
            end

            case (state_q)
                S_IDLE: begin
                    if (clear_req || clr_pend_q) begin
                        clr_pend_q <= 1'b0;
                        if (clear_req) clr_col_q <= clear_colour;
                        clr_cnt_q  <= '0;
                        state_q    <= S_CLEAR;
                    end else if (rd_req) begin
                        rd_oob_q <= rd_oob;
                        if (!rd_oob) mem_addr_q <= pix_addr(rd_y, rd_x);
                        state_q  <= S_READ;
                    end else if (count_q != '0) begin
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (pop) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= fifo_addr_q[rd_ptr_q];
                        mem_wdata_q <= fifo_col_q[rd_ptr_q];
                    end
                    if (count_d == '0 || rd_req || clear_req || clr_pend_q)
                        state_q <= S_IDLE;
                end
                S_READ: state_q <= S_READ_WAIT;
                S_READ_WAIT: begin
                    rd_colour_q <= rd_oob_q ? 3'd0 : mem_rdata;
                    rd_valid_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_CLEAR: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= clr_cnt_q;
                    mem_wdata_q <= clr_col_q;
                    if (clr_cnt_q == LAST_ADDR) begin
                        clear_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 15'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign err_oob    = err_oob_q;
    assign rd_valid   = rd_valid_q;
    assign rd_colour  = rd_colour_q;
    assign clear_done = clear_done_q;
    assign busy       = (state_q != S_IDLE);
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
endmodule

// File: doc/pixel_frame_writer.md
Name: pixel_frame_writer

Overview:
Receiving end of the pixel stream produced by the display renderer. It accepts (x, y, colour) pixel writes through a valid/ready handshake and buffers them in a small FIFO. It drains them into a 160x120, 3-bit-per-pixel frame RAM and also services single-pixel readback requests, which the game logic uses for collision queries. It provides a full-frame clear command for game restart, and sits between the renderer and the frame RAM.

Parameters:
FIFO_DEPTH, 8, pixel-write FIFO entries (power of two)
WIDTH, 160, frame width in pixels
HEIGHT, 120, frame height in pixels

Ports:
clk  input  1  system clock (CLOCK_50 domain)
reset  input  1  asynchronous, active-high reset
in_valid  input  1  pixel write offered
in_ready  output  1  FIFO can accept (registered, = not full)
in_x  input  8  pixel column
in_y  input  7  pixel row
in_colour  input  3  pixel colour
err_oob  output  1  one-cycle pulse: accepted pixel had x>=WIDTH or y>=HEIGHT, so it was dropped
rd_req  input  1  readback request; held high until rd_valid
rd_x  input  8  readback column
rd_y  input  7  readback row
rd_valid  output  1  one-cycle pulse: rd_colour valid
rd_colour  output  3  readback data (held until next readback)
clear_req  input  1  one-cycle pulse: start full-frame clear
clear_colour  input  3  fill colour, sampled when clear_req is accepted
clear_done  output  1  one-cycle pulse at end of clear
busy  output  1  state != S_IDLE
mem_addr  output  15  frame RAM address = y*160 + x
mem_we  output  1  frame RAM write enable
mem_wdata  output  3  frame RAM write data
mem_rdata  input  3  frame RAM read data, valid one cycle after address

Behaviour:
- Reset (async, active-high):
  - FIFO pointers, count and state are cleared; state = S_IDLE.
  - Outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_valid=0, rd_colour=0, clear_done=0, err_oob=0, busy=0.
  - in_ready rises in the first cycle after reset deasserts.
  - Reset during clear or readback aborts the operation. No clear_done or rd_valid is issued.
- Input handshake:
  - A transfer occurs when in_valid && in_ready at a clk edge.
  - in_ready is registered and reflects the FIFO count after the current cycle's push and pop.
  - A pop while full frees a slot visible the next cycle. No push is accepted while in_ready=0.
- Out-of-range pixels: the transfer completes, the pixel is not stored, and err_oob pulses on the following cycle.
- Address arithmetic: mem_addr = (y<<7) + (y<<5) + x, 15 bits, maximum 19199.
- State machine, S_IDLE (priority when several requests are pending): clear_req > rd_req > FIFO non-empty.
  - clear_req: latch clear_colour, set address counter=0, go to S_CLEAR.
  - rd_req: latch rd_x and rd_y, go to S_READ.
  - FIFO non-empty: go to S_WRITE.
- S_WRITE:
  - Each cycle, pop the head entry and drive mem_we=1 with its address and colour.
  - Stay while the FIFO remains non-empty and no rd_req or clear_req is pending; otherwise return to S_IDLE.
  - Sustained throughput is 1 pixel/cycle.
- S_READ: drive mem_addr from the latched coordinates with mem_we=0, then go to S_READ_WAIT.
- S_READ_WAIT: register mem_rdata into rd_colour and pulse rd_valid=1 next cycle, then go to S_IDLE.
  - Latency: rd_req seen in S_IDLE at cycle N gives rd_valid at N+3.
  - rd_req must drop in the cycle after rd_valid. A held rd_req starts a new read.
  - Out-of-range readback returns rd_colour=0 without a RAM access, at the same latency.
- S_CLEAR:
  - Write clear_colour to addresses 0..19199, one per cycle with mem_we=1.
  - After address 19199, pulse clear_done and go to S_IDLE. The clear takes 19200 cycles.
  - The FIFO keeps accepting until full; queued pixels are written after the clear completes.
  - rd_req and a new clear_req are ignored until S_IDLE; a clear_req arriving during a clear is dropped.
- A pixel pushed to an empty FIFO is written no earlier than 2 cycles after acceptance (push, IDLE->WRITE).

Test Plan:
- Reset, then push (x=5, y=3, c=3'b110) -> mem_we=1 with mem_addr=485 and mem_wdata=6 within 3 cycles; err_oob stays 0.
- Hold in_valid for 12 consecutive pixels while stalling RAM drain by a held rd_req -> in_ready=0 after 8 accepts; after rd_valid, all 12 pixels are written in order with no loss or duplication.
- Push (x=160, y=0) and (x=0, y=120) -> err_oob pulses twice and mem_we never asserts for them.
- Write (x=159, y=119, c=3'b011) then rd_req at (159,119) -> mem_addr=19199; rd_valid 3 cycles after rd_req is seen in S_IDLE, with rd_colour=3.
- clear_req with clear_colour=3'b011 -> 19200 writes at addresses 0..19199; clear_done pulses once; busy=1 throughout; a pixel pushed mid-clear is written after clear_done.
- Assert reset at clear address 1000 -> mem_we=0 and busy=0 immediately; no clear_done; FIFO empty; in_ready=1 one cycle after release.
